// File: rtl/hex_display_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with guard interval,
// leading-zero blanking and frame-boundary (tear-free) value updates.

module hex_display_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_blank_lz,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic [2:0]              o_digit_idx,
    output logic                    o_frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0]         CNT_GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0]         CNT_SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0]         SLOT_LAST      = SW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF        = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF         = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF         = {NUM_DIGITS{AN_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_DRIVE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_div_cnt;
    logic [CW-1:0]           w_div_cnt_nxt;
    logic [SW-1:0]           r_slot;
    logic [SW-1:0]           w_slot_nxt;
    logic                    w_frame_end;

    logic [4*NUM_DIGITS-1:0] r_sh_value;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic                    r_sh_blank;
    logic [4*NUM_DIGITS-1:0] r_pd_value;
    logic [NUM_DIGITS-1:0]   r_pd_dp;
    logic                    r_pd_blank;
    logic                    r_pend_valid;

    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [2:0]              r_digit_idx;
    logic                    r_frame_done;

    logic                    w_lit;
    logic [3:0]              w_nibble;
    logic                    w_dp_bit;
    logic                    w_blank;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [6:0]              w_seg_al;
    logic                    w_dp_al;
    logic [NUM_DIGITS-1:0]   w_an_al;
    logic                    w_swap_ok;

    // Glyphs in active-low form, bit6=g .. bit0=a
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b0100111;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_slot    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_slot    <= w_slot_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_slot_nxt    = r_slot;
        w_frame_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_div_cnt_nxt = '0;
                w_slot_nxt    = '0;
                if (i_en) begin
                    w_state_nxt = ST_GUARD;
                end
            end
            ST_GUARD: begin
                w_div_cnt_nxt = r_div_cnt + CW'(1);
                if (r_div_cnt == CNT_GUARD_LAST) begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_div_cnt == CNT_SLOT_LAST) begin
                    w_state_nxt   = ST_GUARD;
                    w_div_cnt_nxt = '0;
                    if (r_slot == SLOT_LAST) begin
                        w_slot_nxt  = '0;
                        w_frame_end = 1'b1;
                    end else begin
                        w_slot_nxt = r_slot + SW'(1);
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (!i_en) begin
            w_state_nxt   = ST_IDLE;
            w_div_cnt_nxt = '0;
            w_slot_nxt    = '0;
        end
    end

    // r_frame_done marks the boundary cycle; slot 0 is still in guard, so the
    // shadow may be replaced here without tearing the displayed frame.
    assign w_swap_ok = (r_state == ST_IDLE) || r_frame_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_value   <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= 1'b0;
            r_pd_value   <= '0;
            r_pd_dp      <= '0;
            r_pd_blank   <= 1'b0;
            r_pend_valid <= 1'b0;
        end else if (w_swap_ok) begin
            if (i_load) begin
                r_sh_value   <= i_value;
                r_sh_dp      <= i_dp_in;
                r_sh_blank   <= i_blank_lz;
                r_pend_valid <= 1'b0;
            end else if (r_pend_valid) begin
                r_sh_value   <= r_pd_value;
                r_sh_dp      <= r_pd_dp;
                r_sh_blank   <= r_pd_blank;
                r_pend_valid <= 1'b0;
            end
        end else if (i_load) begin
            r_pd_value   <= i_value;
            r_pd_dp      <= i_dp_in;
            r_pd_blank   <= i_blank_lz;
            r_pend_valid <= 1'b1;
        end
    end

    // Walk from the top digit down so w_zero_run covers digits k..NUM_DIGITS-1
    always_comb begin
        w_nibble   = '0;
        w_dp_bit   = 1'b0;
        w_blank    = 1'b0;
        w_zero_run = 1'b1;
        w_onehot   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run  = w_zero_run & (r_sh_value[4*k +: 4] == 4'h0);
            w_onehot[k] = (r_slot == SW'(k));
            if (r_slot == SW'(k)) begin
                w_nibble = r_sh_value[4*k +: 4];
                w_dp_bit = r_sh_dp[k];
                w_blank  = r_sh_blank & w_zero_run & (k != 0);
            end
        end
    end

    assign w_lit    = (r_state == ST_DRIVE);
    assign w_seg_al = (w_lit && !w_blank) ? glyph(w_nibble) : 7'h7F;
    assign w_dp_al  = ~(w_lit & w_dp_bit);
    assign w_an_al  = w_lit ? ~w_onehot : {NUM_DIGITS{1'b1}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg        <= SEG_OFF;
            r_dp         <= DP_OFF;
            r_an         <= AN_OFF;
            r_digit_idx  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= SEG_ACTIVE_LOW ? w_seg_al : ~w_seg_al;
            r_dp         <= SEG_ACTIVE_LOW ? w_dp_al : ~w_dp_al;
            r_an         <= AN_ACTIVE_LOW ? w_an_al : ~w_an_al;
            r_digit_idx  <= 3'(r_slot);
            r_frame_done <= w_frame_end & i_en;
        end
    end

    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_an         = r_an;
    assign o_digit_idx  = r_digit_idx;
    assign o_frame_done = r_frame_done;

endmodule

// File: doc/hex_display_scan_driver.md
# hex_display_scan_driver

Time-multiplexed driver for a bank of common-anode 7-segment digits. It takes a packed hex value of NUM_DIGITS nibbles and scans one digit per slot, producing segment, decimal-point and anode outputs with a guard interval between slots to prevent ghosting. It supports leading-zero blanking and tear-free value updates: loads are shadowed and applied only at frame boundaries. It sits between the datapath result registers and the board display pins, and replaces per-digit static decoders.

## Interface
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be >= GUARD+2.
- GUARD, 500: cycles at the start of each slot with all anodes off; must be >= 1.
- SEG_ACTIVE_LOW, 1: 1 means a segment/dp is lit when low; 0 inverts seg and dp.
- AN_ACTIVE_LOW, 1: 1 means a digit is enabled when its anode bit is low; 0 inverts an.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; 0 means display dark and scan held.
- load  in  1  one-cycle strobe that captures value/dp_in/blank_lz.
- value  in  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k, and digit 0 is rightmost/least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit; 1 means lit.
- blank_lz  in  1  leading-zero blanking request.
- seg  out  7  segments g..a (bit6=g, bit0=a).
- dp  out  1  decimal point of the active digit.
- an  out  NUM_DIGITS  one-hot anode enables.
- digit_idx  out  3  index of the slot currently scanned.
- frame_done  out  1  one-cycle pulse at the end of the last digit's slot.

## Operation
- Glyph table in active-low form, bits g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110. With SEG_ACTIVE_LOW=0, every bit is inverted.
- Off/blank means seg all unlit, dp unlit, and all an bits inactive.
- Registers:
  - shadow {value, dp_in, blank_lz}: the displayed copy.
  - pending copy plus pend_valid flag.
  - div_cnt: 0..REFRESH_DIV-1.
  - slot: 0..NUM_DIGITS-1.
- FSM states:
  - IDLE: en=0, outputs off, div_cnt=0, slot=0.
  - GUARD: div_cnt < GUARD, outputs off.
  - DRIVE: div_cnt >= GUARD, an is one-hot at slot, and seg/dp come from shadow nibble `slot`.
- Transitions:
  - IDLE→GUARD when en=1.
  - GUARD→DRIVE when div_cnt reaches GUARD.
  - DRIVE→GUARD when div_cnt=REFRESH_DIV-1: div_cnt←0 and slot←slot+1, wrapping NUM_DIGITS-1→0.
  - Any state→IDLE on the cycle after en=0.
- Frame boundary is a slot wrap to 0.
  - frame_done pulses on the cycle where slot NUM_DIGITS-1 ends.
  - If pend_valid is set, shadow←pending on the same edge and pend_valid is cleared.
- load while en=1 and not at a boundary: the inputs go to pending and pend_valid is set. Multiple loads before a boundary: the last one wins.
- load on the boundary cycle itself: the new inputs go directly to shadow, and any older pending copy is discarded.
- load while in IDLE: the inputs go directly to shadow.
- Leading-zero blanking (shadow blank_lz=1):
  - Digit k is blanked if every nibble from k to NUM_DIGITS-1 is zero and k≠0. Digit 0 is never blanked.
  - A blanked digit keeps its anode active but seg is unlit. dp still follows dp_in.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, div_cnt=0, slot=0.
  - shadow=0, pending=0, pend_valid=0.
  - seg unlit (7'b1111111 when SEG_ACTIVE_LOW=1), dp unlit, an all inactive.
  - digit_idx=0, frame_done=0.
- Reset release takes effect synchronously at the next clk edge.
- Outputs are registered and lag internal state by exactly one clock.
  - The first lit slot after en rises starts GUARD+2 cycles after en is sampled high.
  - Each slot is REFRESH_DIV cycles long; a frame is NUM_DIGITS*REFRESH_DIV cycles.
- Reset asserted mid-frame: outputs go off immediately and any pending load is lost.
- en dropped mid-slot: outputs go off one cycle later. Re-enable restarts at slot 0, in GUARD.
- an is never active for two digits in the same cycle, and there are at least GUARD dark cycles between any two lit slots.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
- Reset: hold rst_n=0, toggle clk and en → seg=7'h7F, an=4'hF, dp=1, frame_done=0; with en=0 after release, all stay unchanged.
- Basic scan: load value=16'h12AF and en=1 → per frame, digit0 seg=0001110 with an=1110, digit1 seg=0001000 with an=1101, digit2 seg=0100100 with an=1011, digit3 seg=1111001 with an=0111. Each slot shows 2 dark cycles then 6 lit cycles; frame_done pulses every 32 cycles.
- Blanking: load value=16'h0030 with blank_lz=1 → digits 3 and 2 unlit with anodes still active; digit1 seg=0110000; digit0 seg=1000000.
  - value=0 → only digit 0 is lit and shows 0.
- Tear-free update: displaying 16'h1111, load 16'h2222 during slot 1, then 16'h3333 during slot 2 → digits 2 and 3 still show 1 for this frame, and the next frame shows 3 on all digits.
- Boundary load: pulse load with 16'h4444 on the frame_done cycle → the next frame shows 4 on all digits.
- en drop during slot 2 → an=4'hF one cycle later; re-enable → the scan restarts at digit_idx=0 after 2 dark cycles.
